// File: rtl/fork_join_seq.sv
// fork_join_seq: a fixed, timed "program" that models fork/join concurrency.
// One run does the following. It sets the source x, waits, then sets y. Fork 1
// copies the sources into a and b on two independent branches. It waits, then
// sets x again. Fork 2 runs four branches that copy into p, a, b and m. The run
// ends with a one-cycle done pulse. Every delay is counted in rising clk edges.
module fork_join_seq #(
    parameter int D_Y  = 5,
    parameter int D_A1 = 20,
    parameter int D_B1 = 15,
    parameter int D_X  = 40,
    parameter int D_P  = 10,
    parameter int D_QA = 10,
    parameter int D_QB = 30,
    parameter int D_M  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       x,
    output logic       y,
    output logic       a,
    output logic       b,
    output logic       p,
    output logic       m,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DLY_Y = 3'd1,
        FORK1 = 3'd2,
        DLY_X = 3'd3,
        FORK2 = 3'd4
    } state_t;

    // A timer cleared on the origin edge holds k-1 just before edge origin+k.
    // The event for a delay D therefore fires when the timer holds D-1.
    localparam logic [7:0] Y_LAST  = 8'(D_Y  - 1);
    localparam logic [7:0] A1_LAST = 8'(D_A1 - 1);
    localparam logic [7:0] B1_LAST = 8'(D_B1 - 1);
    localparam logic [7:0] X_LAST  = 8'(D_X  - 1);
    localparam logic [7:0] P_LAST  = 8'(D_P  - 1);
    localparam logic [7:0] QA_LAST = 8'(D_QA - 1);
    localparam logic [7:0] QB_LAST = 8'(D_QB - 1);
    localparam logic [7:0] M_LAST  = 8'(D_M  - 1);

    state_t     r_state;
    state_t     w_stateNext;

    logic       r_x, r_y, r_a, r_b, r_p, r_m;
    logic       r_done;
    logic [7:0] r_dlyTmr;
    logic [7:0] r_forkTmr;
    logic [7:0] r_qTmr;
    logic       r_doneA, r_doneB;
    logic       r_doneP, r_doneQA, r_doneQB, r_doneM;

    logic       w_go;
    logic       w_fireY, w_fireX;
    logic       w_fireA, w_fireB, w_join1;
    logic       w_fireP, w_fireQA, w_fireQB, w_fireM, w_join2;

    // Saturate the timers so a long wait on one branch cannot wrap a timer and re-trigger another.
    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State register. Reset always returns the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and branch strobes. Abort suppresses every strobe in its cycle.
    always_comb begin
        w_stateNext = r_state;
        w_go        = 1'b0;
        w_fireY     = 1'b0;
        w_fireX     = 1'b0;
        w_fireA     = 1'b0;
        w_fireB     = 1'b0;
        w_join1     = 1'b0;
        w_fireP     = 1'b0;
        w_fireQA    = 1'b0;
        w_fireQB    = 1'b0;
        w_fireM     = 1'b0;
        w_join2     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_go        = 1'b1;
                    w_stateNext = DLY_Y;
                end
            end
            DLY_Y: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_dlyTmr == Y_LAST) begin
                    w_fireY     = 1'b1;
                    w_stateNext = FORK1;
                end
            end
            FORK1: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else begin
                    w_fireA = !r_doneA && (r_forkTmr == A1_LAST);
                    w_fireB = !r_doneB && (r_forkTmr == B1_LAST);
                    w_join1 = (r_doneA || w_fireA) && (r_doneB || w_fireB);
                    if (w_join1) begin
                        w_stateNext = DLY_X;
                    end
                end
            end
            DLY_X: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_dlyTmr == X_LAST) begin
                    w_fireX     = 1'b1;
                    w_stateNext = FORK2;
                end
            end
            FORK2: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else begin
                    w_fireP  = !r_doneP  && (r_forkTmr == P_LAST);
                    w_fireQA = !r_doneQA && (r_forkTmr == QA_LAST);
                    w_fireQB = r_doneQA && !r_doneQB && (r_qTmr == QB_LAST);
                    w_fireM  = !r_doneM  && (r_forkTmr == M_LAST);
                    w_join2  = (r_doneP  || w_fireP)  &&
                               (r_doneQB || w_fireQB) &&
                               (r_doneM  || w_fireM);
                    if (w_join2) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Sources, destinations, timers and branch-completion flags.
    // Q's second leg uses its own timer, so no timer needs more than 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= 1'b0;
            r_y       <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_p       <= 1'b0;
            r_m       <= 1'b0;
            r_done    <= 1'b0;
            r_dlyTmr  <= 8'd0;
            r_forkTmr <= 8'd0;
            r_qTmr    <= 8'd0;
            r_doneA   <= 1'b0;
            r_doneB   <= 1'b0;
            r_doneP   <= 1'b0;
            r_doneQA  <= 1'b0;
            r_doneQB  <= 1'b0;
            r_doneM   <= 1'b0;
        end else begin
            r_done <= w_join2;

            if (r_state == DLY_Y || r_state == DLY_X) begin
                r_dlyTmr <= satInc(r_dlyTmr);
            end
            if (r_state == FORK1 || r_state == FORK2) begin
                r_forkTmr <= satInc(r_forkTmr);
            end
            if (r_state == FORK2) begin
                r_qTmr <= satInc(r_qTmr);
            end

            if (w_go) begin
                r_x      <= 1'b0;
                r_dlyTmr <= 8'd0;
            end

            if (w_fireY) begin
                r_y       <= 1'b1;
                r_forkTmr <= 8'd0;
                r_doneA   <= 1'b0;
                r_doneB   <= 1'b0;
            end

            if (w_fireA) begin
                r_a     <= r_x;
                r_doneA <= 1'b1;
            end
            if (w_fireB) begin
                r_b     <= r_y;
                r_doneB <= 1'b1;
            end
            if (w_join1) begin
                r_dlyTmr <= 8'd0;
            end

            if (w_fireX) begin
                r_x       <= 1'b1;
                r_forkTmr <= 8'd0;
                r_qTmr    <= 8'd0;
                r_doneP   <= 1'b0;
                r_doneQA  <= 1'b0;
                r_doneQB  <= 1'b0;
                r_doneM   <= 1'b0;
            end

            if (w_fireP) begin
                r_p     <= r_x;
                r_doneP <= 1'b1;
            end
            if (w_fireQA) begin
                r_a      <= r_y;
                r_doneQA <= 1'b1;
                r_qTmr   <= 8'd0;
            end
            if (w_fireQB) begin
                r_b      <= r_x;
                r_doneQB <= 1'b1;
            end
            if (w_fireM) begin
                r_m     <= r_y;
                r_doneM <= 1'b1;
            end
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign a     = r_a;
    assign b     = r_b;
    assign p     = r_p;
    assign m     = r_m;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign phase = r_state;

endmodule

// File: tb/tb_fork_join_seq.sv
// Testbench for fork_join_seq. Directed scenarios push hand-computed
// {edge, outputs} expectations into queues. Monitors compare every observed
// change of the output vector against the next queued entry.
// Vector layout: {phase[2:0], busy, done, x, y, a, b, p, m}.
module tb_fork_join_seq;

    logic       clk;
    logic       rst, start, abort;
    logic       x, y, a, b, p, m, busy, done;
    logic [2:0] phase;

    logic       rst2, start2, abort2;
    logic       x2, y2, a2, b2, p2, m2, busy2, done2;
    logic [2:0] phase2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit monOn    = 1'b0;

    typedef struct packed {
        int          t;
        logic [10:0] v;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    fork_join_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .x     (x),
        .y     (y),
        .a     (a),
        .b     (b),
        .p     (p),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .phase (phase)
    );

    fork_join_seq #(.D_A1(3), .D_B1(9), .D_M(50)) dut2 (
        .clk   (clk),
        .rst   (rst2),
        .start (start2),
        .abort (abort2),
        .x     (x2),
        .y     (y2),
        .a     (a2),
        .b     (b2),
        .p     (p2),
        .m     (m2),
        .busy  (busy2),
        .done  (done2),
        .phase (phase2)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, t, act, req);
        end
    endtask

    task automatic failNow(input string name, input int t, input logic [31:0] act);
        checks++;
        failures++;
        $display("[TB] FAIL %s at edge %0d: got %0h, expected no change", name, t, act);
    endtask

    task automatic exp1(input int t, input logic [2:0] ph, input logic bs, input logic dn, input logic [5:0] d);
        exp_t e;
        e.t = t;
        e.v = {ph, bs, dn, d};
        q1.push_back(e);
    endtask

    task automatic exp2(input int t, input logic [2:0] ph, input logic bs, input logic dn, input logic [5:0] d);
        exp_t e;
        e.t = t;
        e.v = {ph, bs, dn, d};
        q2.push_back(e);
    endtask

    // Return at the falling edge just before rising edge e, so inputs set now are sampled at edge e
    task automatic goTo(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic applyStimulus(input int e, input bit s, input bit ab, input bit r);
        goTo(e);
        start = s;
        abort = ab;
        rst   = r;
        goTo(e + 1);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    // Scoreboard monitor for the default-parameter instance
    logic [10:0] prev1;
    always @(negedge clk) begin
        logic [10:0] v;
        exp_t        e;
        if (monOn) begin
            v = {phase, busy, done, x, y, a, b, p, m};
            if (v !== prev1) begin
                if (q1.size() == 0) begin
                    failNow("dut1_unexpected_change", cyc, 32'(v));
                end else begin
                    e = q1.pop_front();
                    checkOutput("dut1_event_edge", cyc, 32'(cyc), 32'(e.t));
                    checkOutput("dut1_event_outputs", cyc, 32'(v), 32'(e.v));
                end
                prev1 = v;
            end
        end
    end

    // Scoreboard monitor for the overridden-parameter instance
    logic [10:0] prev2;
    always @(negedge clk) begin
        logic [10:0] v;
        exp_t        e;
        if (monOn) begin
            v = {phase2, busy2, done2, x2, y2, a2, b2, p2, m2};
            if (v !== prev2) begin
                if (q2.size() == 0) begin
                    failNow("dut2_unexpected_change", cyc, 32'(v));
                end else begin
                    e = q2.pop_front();
                    checkOutput("dut2_event_edge", cyc, 32'(cyc), 32'(e.t));
                    checkOutput("dut2_event_outputs", cyc, 32'(v), 32'(e.v));
                end
                prev2 = v;
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        repeat (5000) @(posedge clk);
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: got edge %0d, expected completion before it", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        rst2   = 1'b1;
        start2 = 1'b0;
        abort2 = 1'b0;
        goTo(4);
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);

        checkOutput("dut1_reset_state", cyc, 32'({phase, busy, done, x, y, a, b, p, m}), 32'd0);
        checkOutput("dut2_reset_state", cyc, 32'({phase2, busy2, done2, x2, y2, a2, b2, p2, m2}), 32'd0);
        prev1 = {phase, busy, done, x, y, a, b, p, m};
        prev2 = {phase2, busy2, done2, x2, y2, a2, b2, p2, m2};
        monOn = 1'b1;

        // Default run at T0=10, with extra starts at T3 and T50 that must be ignored
        exp1( 10, 3'd1, 1'b1, 1'b0, 6'b000000);
        exp1( 15, 3'd2, 1'b1, 1'b0, 6'b010000);
        exp1( 30, 3'd2, 1'b1, 1'b0, 6'b010100);
        exp1( 35, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp1( 75, 3'd4, 1'b1, 1'b0, 6'b110100);
        exp1( 80, 3'd4, 1'b1, 1'b0, 6'b110101);
        exp1( 85, 3'd4, 1'b1, 1'b0, 6'b111111);
        exp1(115, 3'd0, 1'b0, 1'b1, 6'b111111);
        exp1(116, 3'd0, 1'b0, 1'b0, 6'b111111);
        // Abort at T30 of a run starting at 140, then a fresh run at 180
        exp1(130, 3'd0, 1'b0, 1'b0, 6'b000000);
        exp1(140, 3'd1, 1'b1, 1'b0, 6'b000000);
        exp1(145, 3'd2, 1'b1, 1'b0, 6'b010000);
        exp1(160, 3'd2, 1'b1, 1'b0, 6'b010100);
        exp1(165, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp1(170, 3'd0, 1'b0, 1'b0, 6'b010100);
        exp1(180, 3'd1, 1'b1, 1'b0, 6'b010100);
        exp1(185, 3'd2, 1'b1, 1'b0, 6'b010100);
        exp1(205, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp1(245, 3'd4, 1'b1, 1'b0, 6'b110100);
        exp1(250, 3'd4, 1'b1, 1'b0, 6'b110101);
        exp1(255, 3'd4, 1'b1, 1'b0, 6'b111111);
        exp1(285, 3'd0, 1'b0, 1'b1, 6'b111111);
        exp1(286, 3'd0, 1'b0, 1'b0, 6'b111111);
        // Reset at T72 of a run starting at 310 (start with rst also asserted)
        exp1(300, 3'd0, 1'b0, 1'b0, 6'b000000);
        exp1(310, 3'd1, 1'b1, 1'b0, 6'b000000);
        exp1(315, 3'd2, 1'b1, 1'b0, 6'b010000);
        exp1(330, 3'd2, 1'b1, 1'b0, 6'b010100);
        exp1(335, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp1(375, 3'd4, 1'b1, 1'b0, 6'b110100);
        exp1(380, 3'd4, 1'b1, 1'b0, 6'b110101);
        exp1(382, 3'd0, 1'b0, 1'b0, 6'b000000);
        // start held from 400 through 611: two back-to-back runs, with done pulses 106 apart
        exp1(400, 3'd1, 1'b1, 1'b0, 6'b000000);
        exp1(405, 3'd2, 1'b1, 1'b0, 6'b010000);
        exp1(420, 3'd2, 1'b1, 1'b0, 6'b010100);
        exp1(425, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp1(465, 3'd4, 1'b1, 1'b0, 6'b110100);
        exp1(470, 3'd4, 1'b1, 1'b0, 6'b110101);
        exp1(475, 3'd4, 1'b1, 1'b0, 6'b111111);
        exp1(505, 3'd0, 1'b0, 1'b1, 6'b111111);
        exp1(506, 3'd1, 1'b1, 1'b0, 6'b011111);
        exp1(511, 3'd2, 1'b1, 1'b0, 6'b011111);
        exp1(531, 3'd3, 1'b1, 1'b0, 6'b010111);
        exp1(571, 3'd4, 1'b1, 1'b0, 6'b110111);
        exp1(581, 3'd4, 1'b1, 1'b0, 6'b111111);
        exp1(611, 3'd0, 1'b0, 1'b1, 6'b111111);
        exp1(612, 3'd0, 1'b0, 1'b0, 6'b111111);

        // Overridden instance: D_A1=3, D_B1=9, D_M=50, run at T0=10
        exp2( 10, 3'd1, 1'b1, 1'b0, 6'b000000);
        exp2( 15, 3'd2, 1'b1, 1'b0, 6'b010000);
        exp2( 24, 3'd3, 1'b1, 1'b0, 6'b010100);
        exp2( 64, 3'd4, 1'b1, 1'b0, 6'b110100);
        exp2( 74, 3'd4, 1'b1, 1'b0, 6'b111110);
        exp2(114, 3'd0, 1'b0, 1'b1, 6'b111111);
        exp2(115, 3'd0, 1'b0, 1'b0, 6'b111111);

        goTo(10);
        start2 = 1'b1;
        applyStimulus(10, 1'b1, 1'b0, 1'b0);
        start2 = 1'b0;
        applyStimulus(13, 1'b1, 1'b0, 1'b0);
        applyStimulus(60, 1'b1, 1'b0, 1'b0);

        applyStimulus(130, 1'b0, 1'b0, 1'b1);
        applyStimulus(140, 1'b1, 1'b0, 1'b0);
        applyStimulus(170, 1'b0, 1'b1, 1'b0);
        applyStimulus(180, 1'b1, 1'b0, 1'b0);
        applyStimulus(290, 1'b0, 1'b1, 1'b0);
        applyStimulus(295, 1'b1, 1'b1, 1'b0);

        applyStimulus(300, 1'b0, 1'b0, 1'b1);
        applyStimulus(310, 1'b1, 1'b0, 1'b0);
        applyStimulus(382, 1'b1, 1'b0, 1'b1);

        goTo(400);
        start = 1'b1;
        goTo(612);
        start = 1'b0;
        goTo(640);

        checkOutput("dut1_events_remaining", cyc, 32'(q1.size()), 32'd0);
        checkOutput("dut2_events_remaining", cyc, 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
